regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Shares the single write port of the 32x32 register file between two independent writeback requesters, A and B (for example ALU writeback and load return). Each requester pushes (register select, data) pairs into a small private FIFO through a valid/ready handshake. A round-robin arbiter drains the FIFOs one write per cycle onto registered `we`/`wsel`/`wdata` outputs, which drive the register file write port directly.

## Interface

Parameters:
- `DEPTH`, 2: entries per requester FIFO; power of two, ≥2.
- `AW`, 5: register select width.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `a_valid`  in  1  requester A offers a write.
- `a_ready`  out  1  A FIFO can accept.
- `a_sel`  in  AW  A destination register.
- `a_data`  in  DW  A write data.
- `b_valid`, `b_ready`, `b_sel`, `b_data`: same as A, for requester B.
- `we`  out  1  register file write enable.
- `wsel`  out  AW  register file write select.
- `wdata`  out  DW  register file write data.
- `busy`  out  1  a write is queued or `we` is high.

## Operation

- **Accept:**
  - A entry is pushed on a rising edge where `x_valid && x_ready`.
  - `x_ready = !full(x)`, from FIFO state only.
  - A full FIFO holds ready low even in a cycle where it is popped; there is no pass-through.
- **FIFO:**
  - Per-requester circular buffer with read/write pointers that wrap at `DEPTH`.
  - Occupancy counter 0..`DEPTH`.
  - Strict FIFO order within a requester.
  - Push and pop in the same cycle leave occupancy unchanged.
- **Arbitration (combinational, from FIFO state):**
  - Only one FIFO non-empty: grant it.
  - Both non-empty: grant the requester not granted most recently.
  - Neither non-empty: no grant.
  - The `last` register updates only on a grant.
  - Reset value of `last` is B, so A wins the first tie.
- **Issue:**
  - The granted head is popped at the edge.
  - On the same edge the output registers load `wsel`/`wdata` from the head, and `we` is set to 1 if the head's select ≠ 0.
  - No grant: `we` <= 0; `wsel`/`wdata` hold their previous values.
- **Register 0:**
  - Writes to register 0 are accepted, popped and discarded; `we` stays 0 for that slot.
  - The slot still counts as a grant for round-robin.
- **Cross-requester ordering:**
  - Same `wsel` from A and B: issue order is the grant order, and the later issue wins.
  - No other ordering guarantee between requesters.
- `busy = nonempty(A) | nonempty(B) | we`.
- Data path widths are fixed at `DW`/`AW`; no arithmetic on data.

## Timing

- **Reset:**
  - While `reset` = 0, asynchronously: `we`=0, `wsel`=0, `wdata`=0, both FIFOs empty (`a_ready`=`b_ready`=1), `busy`=0, `last`=B.
  - Reset mid-operation discards all queued and in-flight writes; `we` falls without waiting for a clock edge.
  - The first accept is possible on the first rising edge after release.
- **Latency:**
  - Entry accepted at edge k into an empty, uncontended FIFO: `we` high from edge k+1 to edge k+2.
  - The register file commits at edge k+2.
- **Throughput:**
  - One write per cycle total.
  - Under contention each requester gets every second slot.
  - A single active requester gets every slot and never sees `ready` low.
- **Full boundary:**
  - With both streaming every cycle and `DEPTH`=2, each FIFO reaches full.
  - Thereafter each `ready` toggles low/high, sustaining 1 accept per 2 cycles per requester.
- **Empty boundary:** the grant goes to the other FIFO the same cycle; no idle bubble while either FIFO is non-empty.
- **Handshake:**
  - Requesters must hold `sel`/`data` stable while `valid` is high and `ready` is low.
  - `valid` may drop without a transfer; the block does not check this.

## Test plan

1. **Reset:** hold `reset`=0 for 4 cycles with `a_valid`=1 → `we`=0, `wsel`=0, `wdata`=0, `a_ready`=`b_ready`=1, `busy`=0; no push occurs.
2. **Single write:** A pushes `sel`=5, `data`=0x0000_1234 at edge k → `we`=1, `wsel`=5, `wdata`=0x1234 for exactly one cycle (k+1..k+2); a register file read of r5 then returns 0x1234; `busy` low after edge k+2.
3. **Contention:** A pushes `sel` 1..4 and B pushes `sel` 17..20 (data = `sel`), both `valid` every cycle from the same edge → issue order 1, 17, 2, 18, 3, 19, 4, 20; each `ready` drops once its FIFO is full; 8 `we` pulses in total; no loss or duplication.
4. **Register 0:** A pushes `sel`=0, `data`=0xDEAD_BEEF, then `sel`=3, `data`=7 → one cycle with `we`=0 and `busy`=1, then `we`=1 with `wsel`=3; r0 is unchanged.
5. **Round-robin memory:** B-only stream of 3 entries, then A and B both non-empty → A is granted first, since `last`=B.
6. **Reset mid-stream:** 2 entries queued in each FIFO and `we`=1, assert `reset` between edges → `we` falls immediately; after release no `we` pulse occurs until a new push, and `a_ready`=`b_ready`=1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two writeback requesters (A, B) share the single write
// port of a 32x32 register file. Each requester has a private FIFO. A
// round-robin arbiter drains one entry per cycle onto registered
// we/wsel/wdata. Writes to register 0 use an issue slot but leave we low.

// Per-requester circular FIFO holding (select, data) pairs.
module regfile_wb_fifo #(
   parameter int DEPTH = 2,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [AW-1:0] i_sel,
   input  logic [DW-1:0] i_data,
   output logic          o_full,
   output logic          o_nonempty,
   output logic [AW-1:0] o_head_sel,
   output logic [DW-1:0] o_head_data
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [AW-1:0] r_mem_sel  [DEPTH];
   logic [DW-1:0] r_mem_data [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   // Storage write: a pushed entry lands at the write pointer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_sel[i]  <= '0;
            r_mem_data[i] <= '0;
         end
      end else if (i_push) begin
         r_mem_sel[r_wptr]  <= i_sel;
         r_mem_data[r_wptr] <= i_data;
      end else begin
         r_mem_sel[r_wptr]  <= r_mem_sel[r_wptr];
         r_mem_data[r_wptr] <= r_mem_data[r_wptr];
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_wptr <= r_wptr + PW'(1);
         end else begin
            r_wptr <= r_wptr;
         end
         if (i_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end else begin
            r_rptr <= r_rptr;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_full      = (r_count == CW'(DEPTH));
   assign o_nonempty  = (r_count != '0);
   assign o_head_sel  = r_mem_sel[r_rptr];
   assign o_head_data = r_mem_data[r_rptr];
endmodule

module regfile_wb_arbiter #(
   parameter int DEPTH = 2,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [AW-1:0] a_sel,
   input  logic [DW-1:0] a_data,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic [AW-1:0] b_sel,
   input  logic [DW-1:0] b_data,
   output logic          we,
   output logic [AW-1:0] wsel,
   output logic [DW-1:0] wdata,
   output logic          busy
);
   typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_e;

   logic          w_a_full, w_a_ne, w_a_push;
   logic          w_b_full, w_b_ne, w_b_push;
   logic [AW-1:0] w_a_head_sel,  w_b_head_sel;
   logic [DW-1:0] w_a_head_data, w_b_head_data;
   logic          w_grant_a, w_grant_b;
   logic [AW-1:0] w_head_sel;
   logic [DW-1:0] w_head_data;

   req_e          r_last;
   logic          r_we;
   logic [AW-1:0] r_wsel;
   logic [DW-1:0] r_wdata;

   // Ready depends on FIFO state only: a full FIFO refuses even while popping.
   assign w_a_push = a_valid & ~w_a_full;
   assign w_b_push = b_valid & ~w_b_full;

   regfile_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo_a (
      .i_clk       (clk),
      .i_rst_n     (reset),
      .i_push      (w_a_push),
      .i_pop       (w_grant_a),
      .i_sel       (a_sel),
      .i_data      (a_data),
      .o_full      (w_a_full),
      .o_nonempty  (w_a_ne),
      .o_head_sel  (w_a_head_sel),
      .o_head_data (w_a_head_data)
   );

   regfile_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo_b (
      .i_clk       (clk),
      .i_rst_n     (reset),
      .i_push      (w_b_push),
      .i_pop       (w_grant_b),
      .i_sel       (b_sel),
      .i_data      (b_data),
      .o_full      (w_b_full),
      .o_nonempty  (w_b_ne),
      .o_head_sel  (w_b_head_sel),
      .o_head_data (w_b_head_data)
   );

   // Round-robin grant: on a tie the requester not served last wins.
   always_comb begin
      w_grant_a = 1'b0;
      w_grant_b = 1'b0;
      if (w_a_ne && w_b_ne) begin
         if (r_last == REQ_B) begin
            w_grant_a = 1'b1;
         end else begin
            w_grant_b = 1'b1;
         end
      end else if (w_a_ne) begin
         w_grant_a = 1'b1;
      end else if (w_b_ne) begin
         w_grant_b = 1'b1;
      end else begin
         w_grant_a = 1'b0;
         w_grant_b = 1'b0;
      end
   end

   // Select the granted head for the output registers.
   always_comb begin
      w_head_sel  = '0;
      w_head_data = '0;
      if (w_grant_a) begin
         w_head_sel  = w_a_head_sel;
         w_head_data = w_a_head_data;
      end else begin
         w_head_sel  = w_b_head_sel;
         w_head_data = w_b_head_data;
      end
   end

   // Remember who was served; register-0 slots count as grants too.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last <= REQ_B;
      end else if (w_grant_a) begin
         r_last <= REQ_A;
      end else if (w_grant_b) begin
         r_last <= REQ_B;
      end else begin
         r_last <= r_last;
      end
   end

   // Write-port registers: load the granted head, suppress we for register 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we    <= 1'b0;
         r_wsel  <= '0;
         r_wdata <= '0;
      end else if (w_grant_a || w_grant_b) begin
         r_we    <= (w_head_sel != '0);
         r_wsel  <= w_head_sel;
         r_wdata <= w_head_data;
      end else begin
         r_we    <= 1'b0;
         r_wsel  <= r_wsel;
         r_wdata <= r_wdata;
      end
   end

   assign a_ready = ~w_a_full;
   assign b_ready = ~w_b_full;
   assign we      = r_we;
   assign wsel    = r_wsel;
   assign wdata   = r_wdata;
   assign busy    = w_a_ne | w_b_ne | r_we;
endmodule
